// File: rtl/huffman_stream_encoder.sv
// Streaming Huffman encoder: per-symbol code table lookup,
// LSB-first bit packing into OUT_W-bit words, and a flush/done sequence.
module huffman_stream_encoder #(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 15,
    parameter int OUT_W   = 32,
    localparam int LW     = $clog2(MAX_LEN + 1),
    localparam int CW     = $clog2(OUT_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tbl_we,
    input  logic [SYM_W-1:0]   tbl_addr,
    input  logic [MAX_LEN-1:0] tbl_code,
    input  logic [LW-1:0]      tbl_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SYM_W-1:0]   in_sym,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CW-1:0]      out_nbits,
    output logic               out_last,
    output logic               done,
    output logic               err,
    output logic [31:0]        sym_count,
    output logic [31:0]        bit_count
);

    localparam int AW    = OUT_W + MAX_LEN;
    localparam int FW    = $clog2(AW + 1);
    localparam int DEPTH = 1 << SYM_W;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [FW-1:0]   fill_q, fill_d;
    logic            err_q, err_d;
    logic [31:0]     sym_cnt_q, sym_cnt_d;
    logic [31:0]     bit_cnt_q, bit_cnt_d;

    logic [MAX_LEN-1:0] code_mem_q [DEPTH];
    logic [LW-1:0]      len_mem_q  [DEPTH];

    logic               full;
    logic [FW-1:0]      take_n;
    logic               accept;
    logic               fire;
    logic [MAX_LEN-1:0] lk_code;
    logic [LW-1:0]      lk_len;
    logic [AW-1:0]      ins;

    assign full    = fill_q >= FW'(OUT_W);
    assign take_n  = full ? FW'(OUT_W) : fill_q;
    assign lk_code = code_mem_q[in_sym];
    assign lk_len  = len_mem_q[in_sym];
    assign ins     = (AW'(lk_code) & ((AW'(1) << lk_len) - AW'(1))) << fill_q;

    assign in_ready  = reset && (state_q == RUN) && !full;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign out_data  = acc_q[OUT_W-1:0];
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign sym_count = sym_cnt_q;
    assign bit_count = bit_cnt_q;

    // Output word qualification depends on whether the stream is draining
    always_comb begin
        out_valid = 1'b0;
        out_nbits = CW'(OUT_W);
        out_last  = 1'b0;
        unique case (state_q)
            RUN: out_valid = full;
            FLUSH: begin
                out_valid = (fill_q != '0);
                out_nbits = CW'(take_n);
                out_last  = (fill_q <= FW'(OUT_W));
            end
            default: ;
        endcase
    end

    // Accumulator, counters and state sequencing
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        err_d     = err_q;
        sym_cnt_d = sym_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            acc_d     = acc_q | ins;
            fill_d    = fill_q + FW'(lk_len);
            sym_cnt_d = sym_cnt_q + 32'd1;
            if (lk_len == '0) err_d = 1'b1;
        end
        if (fire) begin
            acc_d     = acc_q >> OUT_W;
            fill_d    = fill_q - take_n;
            bit_cnt_d = bit_cnt_q + 32'(take_n);
        end
        unique case (state_q)
            RUN: if (flush) state_d = FLUSH;
            FLUSH: if (fill_q == '0 || (fire && out_last)) state_d = DONE;
            DONE: begin
                state_d = RUN;
                acc_d   = '0;
                fill_d  = '0;
            end
            default: state_d = RUN;
        endcase
    end

    // Datapath and control registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            acc_q     <= '0;
            fill_q    <= '0;
            err_q     <= 1'b0;
            sym_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            err_q     <= err_d;
            sym_cnt_q <= sym_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Code table; a same-cycle lookup still sees the previous entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                code_mem_q[i] <= '0;
                len_mem_q[i]  <= '0;
            end
        end else if (tbl_we) begin
            code_mem_q[tbl_addr] <= tbl_code;
            len_mem_q[tbl_addr]  <= tbl_len;
        end
    end

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Randomized bench for huffman_stream_encoder against a
// bit-queue reference model, plus directed packing scenarios.
module tb_huffman_stream_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tbl_we = 1'b0;
    logic [7:0]  tbl_addr = '0;
    logic [14:0] tbl_code = '0;
    logic [3:0]  tbl_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_sym = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [5:0]  out_nbits;
    logic        out_last;
    logic        done;
    logic        err;
    logic [31:0] sym_count;
    logic [31:0] bit_count;

    huffman_stream_encoder dut (
        .clk(clk), .reset(reset),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_code(tbl_code), .tbl_len(tbl_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_nbits(out_nbits),
        .out_last(out_last), .done(done), .err(err),
        .sym_count(sym_count), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: pending bits in transmit order
    bit          mq[$];
    logic [14:0] mcode [256];
    int          mlen  [256];
    int          mode;
    logic        merr;
    logic [31:0] msym, mbits;
    logic [31:0] words[$];
    int          nbs[$];
    bit          lasts[$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        mq.delete();
        for (int i = 0; i < 256; i++) begin
            mcode[i] = '0;
            mlen[i]  = 0;
        end
        mode  = 0;
        merr  = 1'b0;
        msym  = '0;
        mbits = '0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sym_count", sym_count, 0);
        chk("rst_bit_count", bit_count, 0);
    endtask

    // One clock: check at negedge, update model, advance past posedge
    task automatic tick();
        bit          ev, rdy, lst, was_empty, last_fired;
        int          nb, sz, ln;
        logic [31:0] w;
        @(negedge clk);
        sz  = mq.size();
        ev  = (mode == 0 && sz >= 32) || (mode == 1 && sz > 0);
        rdy = (mode == 0 && sz < 32);
        nb  = (mode == 1 && sz < 32) ? sz : 32;
        lst = (mode == 1 && sz <= 32);
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, ev);
        chk("done", done, mode == 2);
        chk("err", err, merr);
        chk("sym_count", sym_count, msym);
        chk("bit_count", bit_count, mbits);
        w = '0;
        if (ev) begin
            for (int i = 0; i < nb; i++) w[i] = mq[i];
            chk("out_data", out_data, w);
            chk("out_nbits", out_nbits, nb);
            chk("out_last", out_last, lst);
        end
        was_empty  = (sz == 0);
        last_fired = 1'b0;
        if (ev && out_ready) begin
            words.push_back(w);
            nbs.push_back(nb);
            lasts.push_back(lst);
            repeat (nb) void'(mq.pop_front());
            mbits      = mbits + 32'(nb);
            last_fired = lst;
        end
        if (in_valid && rdy) begin
            ln = mlen[in_sym];
            for (int i = 0; i < ln; i++) mq.push_back(mcode[in_sym][i]);
            msym = msym + 1;
            if (ln == 0) merr = 1'b1;
        end
        if (tbl_we) begin
            mcode[tbl_addr] = tbl_code;
            mlen[tbl_addr]  = int'(tbl_len);
        end
        case (mode)
            0: if (flush) mode = 1;
            1: if (was_empty || last_fired) mode = 2;
            default: mode = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic load(logic [7:0] a, logic [14:0] c, logic [3:0] l);
        tbl_we   = 1'b1;
        tbl_addr = a;
        tbl_code = c;
        tbl_len  = l;
        tick();
        tbl_we   = 1'b0;
    endtask

    task automatic send(logic [7:0] s, int n);
        int target, g;
        target   = int'(msym) + n;
        in_sym   = s;
        g        = 0;
        while (int'(msym) < target && g < 200) begin
            in_valid = 1'b1;
            tick();
            g++;
        end
        in_valid = 1'b0;
        chk("send_timeout", msym, 32'(target));
    endtask

    task automatic drain();
        int g;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush     = 1'b0;
        g         = 0;
        while (mode != 0 && g < 300) begin
            tick();
            g++;
        end
        chk("drain_timeout", mode, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        mreset();
        chk_reset_outs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] syms[8];

    initial begin
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();
        reset = 1'b1;

        // Basic pack
        out_ready = 1'b1;
        words.delete(); nbs.delete(); lasts.delete();
        load(8'h41, 15'b101, 4'd3);
        send(8'h41, 11);
        drain();
        chk("basic_nwords", words.size(), 2);
        chk("basic_w0", words[0], 32'h6DB6DB6D);
        chk("basic_nb0", nbs[0], 32);
        chk("basic_w1", words[1], 32'h1);
        chk("basic_nb1", nbs[1], 1);
        chk("basic_last", lasts[1], 1);
        chk("basic_bits", bit_count, 33);
        chk("basic_syms", sym_count, 11);

        // Maximum code length
        words.delete(); nbs.delete(); lasts.delete();
        load(8'hFF, 15'h7FFF, 4'd15);
        send(8'hFF, 3);
        drain();
        chk("maxlen_nwords", words.size(), 2);
        chk("maxlen_w0", words[0], 32'hFFFFFFFF);
        chk("maxlen_w1", words[1], 32'h00001FFF);
        chk("maxlen_nb1", nbs[1], 13);
        chk("maxlen_last", lasts[1], 1);

        // Backpressure with a full word pending
        words.delete(); nbs.delete(); lasts.delete();
        out_ready = 1'b0;
        send(8'hFF, 3);
        in_valid  = 1'b1;
        repeat (5) begin
            tick();
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        drain();
        chk("bp_nwords", words.size(), 2);
        chk("bp_w0", words[0], 32'hFFFFFFFF);

        // Zero-length code, then a flush with nothing pending
        send(8'h13, 1);
        repeat (3) tick();
        chk("zlen_err", err, 1);
        words.delete(); nbs.delete(); lasts.delete();
        drain();
        chk("zlen_nwords", words.size(), 0);

        // Empty flush straight after reset
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        @(negedge clk);
        chk("empty_done", done, 1);
        @(posedge clk);
        #1;
        mode = 0;

        // Reset while flushing with 20 bits pending
        load(8'h22, 15'h13, 4'd5);
        out_ready = 1'b0;
        send(8'h22, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("mid_pending", out_valid, 1);
        reset = 1'b0;
        #1;
        mreset();
        chk_reset_outs();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();

        // Randomized traffic
        for (int i = 0; i < 8; i++) begin
            syms[i] = 8'($urandom);
            load(syms[i], 15'($urandom), 4'($urandom_range(1, 15)));
        end
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sym    = ($urandom_range(0, 31) == 0) ? 8'($urandom)
                                                     : syms[$urandom_range(0, 7)];
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 59) == 0);
            tbl_we    = ($urandom_range(0, 49) == 0);
            tbl_addr  = syms[$urandom_range(0, 7)];
            tbl_code  = 15'($urandom);
            tbl_len   = 4'($urandom_range(0, 15));
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        tbl_we   = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
